// File: rtl/read_sched_pkg.sv
// Shared state encoding and width helpers for the multi-channel read command scheduler.
package read_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int STALL_CNT_W = 32;

  function automatic int burst_shift(input int burst_bytes);
    return $clog2(burst_bytes);
  endfunction

  // Ceil of the largest byte count needs one bit beyond the shifted size.
  function automatic int bcnt_width(input int xfer_w, input int burst_bytes);
    return xfer_w - $clog2(burst_bytes) + 1;
  endfunction

  function automatic int ost_width(input int max_ost);
    return $clog2(max_ost + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the pointer (combinational);
// on advance the pointer moves to the requester after the one granted.
module rr_arbiter
  import read_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] request,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = idx_width(N);

  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        found      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/read_cmd_scheduler.sv
// Issues burst read commands for NUM_READ_CHANNELS channels over one registered valid/ready port.
// Defining READ_SCHED_PERF_CNT_EN adds the saturating stall_cycles counter output.
module read_cmd_scheduler
  import read_sched_pkg::*;
#(
  parameter int NUM_READ_CHANNELS  = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 64,
  parameter int C_BURST_SIZE_BYTES = 1024,
  parameter int C_MAX_OUTSTANDING  = 16
) (
  input  logic                                                 aclk,
  input  logic                                                 aresetn,
  input  logic                                                 read_start,
  input  logic [NUM_READ_CHANNELS-1:0][C_M_AXI_ADDR_WIDTH-1:0] read_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]                         read_size_in_bytes,
  input  logic [NUM_READ_CHANNELS-1:0]                         chan_ready,
  output logic                                                 cmd_valid,
  input  logic                                                 cmd_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                        cmd_addr,
  output logic [idx_width(NUM_READ_CHANNELS)-1:0]              cmd_chan,
  output logic                                                 cmd_last,
  input  logic [NUM_READ_CHANNELS-1:0]                         burst_done,
  output logic                                                 busy,
  output logic                                                 single_run_read_done,
  output logic                                                 start_err
`ifdef READ_SCHED_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]                               stall_cycles
`endif
);

  localparam int N     = NUM_READ_CHANNELS;
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int XW    = C_XFER_SIZE_WIDTH;
  localparam int SHIFT = burst_shift(C_BURST_SIZE_BYTES);
  localparam int BW    = bcnt_width(XW, C_BURST_SIZE_BYTES);
  localparam int OW    = ost_width(C_MAX_OUTSTANDING);
  localparam int CW    = idx_width(N);
  localparam logic [XW-1:0] REM_MASK  = XW'(C_BURST_SIZE_BYTES - 1);
  localparam logic [AW-1:0] BURST_INC = AW'(C_BURST_SIZE_BYTES);

  state_e               state_q, state_d;
  logic [N-1:0][AW-1:0] addr_q, addr_d, addr_hs;
  logic [N-1:0][BW-1:0] rem_q, rem_d, rem_hs;
  logic [XW-1:0]        size_q, size_d;
  logic [OW-1:0]        ost_q, ost_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [AW-1:0]        cmd_addr_q, cmd_addr_d;
  logic [CW-1:0]        cmd_chan_q, cmd_chan_d;
  logic                 cmd_last_q, cmd_last_d;
  logic                 start_err_q, start_err_d;

  logic                 hs, ost_room, arb_adv;
  logic [N-1:0]         eligible, grant;
  logic [CW-1:0]        grant_idx;
  logic [BW-1:0]        load_bcnt;
  logic [31:0]          ost_up, ost_dn;

  assign hs        = cmd_valid_q && cmd_ready;
  assign load_bcnt = BW'(size_q >> SHIFT) + BW'(|(size_q & REM_MASK));

  // View of the channel tables after this cycle's handshake, so a grant on an
  // accepting cycle never re-issues a burst that has just been handed off.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_hs[i] = addr_q[i];
      rem_hs[i]  = rem_q[i];
      if (hs && int'(cmd_chan_q) == i) begin
        addr_hs[i] = addr_q[i] + BURST_INC;
        rem_hs[i]  = rem_q[i] - 1'b1;
      end
    end
  end

  // The command being accepted this cycle already occupies an outstanding slot.
  assign ost_room = (32'(ost_q) + 32'(hs)) < 32'(C_MAX_OUTSTANDING);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = (rem_hs[i] != '0) && chan_ready[i] && ost_room;
    end
  end

  assign arb_adv = (state_q == ST_ISSUE) && (!cmd_valid_q || hs) && (|eligible);

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .request (eligible),
    .advance (arb_adv),
    .grant   (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = CW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_hs;
    rem_d       = rem_hs;
    size_d      = size_q;
    cmd_valid_d = cmd_valid_q && !hs;
    cmd_addr_d  = cmd_addr_q;
    cmd_chan_d  = cmd_chan_q;
    cmd_last_d  = cmd_last_q;
    start_err_d = start_err_q;
    ost_d       = ost_q;

    // Completions beyond what is outstanding are dropped and flagged.
    ost_up = 32'(ost_q) + 32'(hs);
    ost_dn = 32'($countones(burst_done));
    if (ost_dn > ost_up) begin
      ost_d       = '0;
      start_err_d = 1'b1;
    end else begin
      ost_d = OW'(ost_up - ost_dn);
    end

    if (read_start && state_q != ST_IDLE) start_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (read_start) begin
          state_d = ST_LOAD;
          addr_d  = read_addr;
          size_d  = read_size_in_bytes;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < N; i++) rem_d[i] = load_bcnt;
        state_d = (load_bcnt == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (arb_adv) begin
          cmd_valid_d = 1'b1;
          cmd_addr_d  = addr_hs[grant_idx];
          cmd_chan_d  = grant_idx;
          cmd_last_d  = (rem_hs[grant_idx] == BW'(1));
        end
        if (rem_d == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ost_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      size_q      <= '0;
      ost_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_chan_q  <= '0;
      cmd_last_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      size_q      <= size_d;
      ost_q       <= ost_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_chan_q  <= cmd_chan_d;
      cmd_last_q  <= cmd_last_d;
      start_err_q <= start_err_d;
    end
  end

  assign cmd_valid            = cmd_valid_q;
  assign cmd_addr             = cmd_addr_q;
  assign cmd_chan             = cmd_chan_q;
  assign cmd_last             = cmd_last_q;
  assign busy                 = (state_q != ST_IDLE);
  assign single_run_read_done = (state_q == ST_DONE);
  assign start_err            = start_err_q;

`ifdef READ_SCHED_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (state_q == ST_LOAD) begin
      stall_cycles_d = '0;
    end else if ((state_q == ST_ISSUE || state_q == ST_DRAIN) &&
                 ((cmd_valid_q && !cmd_ready) || !(|eligible)) &&
                 (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  // No stall accounting in this build.
`endif

endmodule
